// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction cache.
//   ICACHE_LINE_BYTES : bytes per cache line (16, four 32-bit instructions)
//   ICACHE_OFF_W      : byte-offset bits inside a line
//   ICACHE_LADDR_W    : width of a line address (addr[31:ICACHE_OFF_W])
//   icache_line_t     : one cache line / fetch window
//   icache_state_e    : refill FSM states
// -----------------------------------------------------------------------------
package icache_pkg;
  localparam int ICACHE_LINE_BYTES = 16;
  localparam int ICACHE_OFF_W      = $clog2(ICACHE_LINE_BYTES);
  localparam int ICACHE_LADDR_W    = 32 - ICACHE_OFF_W;

  typedef logic [127:0] icache_line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } icache_state_e;
endpackage

// File: rtl/icache_refill.sv
// -----------------------------------------------------------------------------
// icache_refill
// Refill FSM and memory-side handshake for the instruction cache.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   miss, miss_line     : window miss and the first missing line address
//   flush               : invalidate request (affects fill acceptance)
//   mem_req, mem_addr   : registered line fill request / line byte address
//   mem_ready           : memory accepts the request
//   mem_data, mem_valid : fill data and its one-cycle strobe
//   wr_en/idx/tag/data  : single line write into the cache arrays
//   miss_start          : pulses on every IDLE->REQ transition
//   state               : current FSM state (debug)
//
// Handshake: a request is transferred on a rising edge where mem_req and
// mem_ready are both high; mem_req and mem_addr stay stable until then.
// Exactly one mem_valid pulse answers each transferred request; mem_valid
// seen while not in WAIT is ignored.
// -----------------------------------------------------------------------------
module icache_refill
  import icache_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = ICACHE_LADDR_W - 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      miss,
  input  logic [ICACHE_LADDR_W-1:0] miss_line,
  input  logic                      flush,
  output logic                      mem_req,
  output logic [31:0]               mem_addr,
  input  logic                      mem_ready,
  input  logic [127:0]              mem_data,
  input  logic                      mem_valid,
  output logic                      wr_en,
  output logic [IDX_W-1:0]          wr_idx,
  output logic [TAG_W-1:0]          wr_tag,
  output icache_line_t              wr_data,
  output logic                      miss_start,
  output logic [1:0]                state
);

  icache_state_e             state_r, state_n;
  logic                      req_r;
  logic [ICACHE_LADDR_W-1:0] line_r;
  // Set by a flush seen while waiting for data: the in-flight fill is stale.
  logic                      drop_r, drop_n;

  always_comb begin
    state_n    = state_r;
    drop_n     = drop_r;
    miss_start = 1'b0;
    wr_en      = 1'b0;
    case (state_r)
      IDLE: begin
        if (miss && !flush) begin
          state_n    = REQ;
          miss_start = 1'b1;
        end
      end
      REQ: begin
        // A flush here does not cancel: the request still completes.
        if (mem_ready) state_n = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          state_n = IDLE;
          drop_n  = 1'b0;
          wr_en   = !flush && !drop_r;
        end else if (flush) begin
          drop_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      line_r  <= '0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      drop_r  <= drop_n;
      req_r   <= (state_n == REQ);
      if (miss_start) line_r <= miss_line;
    end
  end

  assign mem_req  = req_r;
  assign mem_addr = {line_r, {ICACHE_OFF_W{1'b0}}};
  assign wr_idx   = line_r[IDX_W-1:0];
  assign wr_tag   = line_r[ICACHE_LADDR_W-1 -: TAG_W];
  assign wr_data  = mem_data;
  assign state    = state_r;

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped instruction cache returning a 16-byte, four-instruction
// window combinationally on a hit. The window may straddle two lines
// (A = addr[31:4], B = A+1 wrapping), both of which must be present.
// Misses are refilled one line at a time by icache_refill, line A first.
// Ports:
//   clock, reset            : rising-edge clock, asynchronous active-low reset
//   core2icache_addr        : fetch PC (bits [1:0] ignored)
//   icache_flush            : invalidate all lines at the next edge
//   icache2core_data        : window, word 0 at [31:0]; zero when not valid
//   icache2core_data_valid  : whole window hits
//   icache2mem_req/addr     : registered line fill request
//   mem2icache_ready        : memory accepts the fill request
//   mem2icache_data/valid   : fill line and its strobe
//   icache_state            : refill FSM state (debug)
//   icache_hit_count        : hit cycles, wrapping   (ICACHE_STATS_EN only)
//   icache_miss_count       : fills started, wrapping (ICACHE_STATS_EN only)
// Build option: define ICACHE_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module icache
  import icache_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  core2icache_addr,
  input  logic         icache_flush,
  output logic [127:0] icache2core_data,
  output logic         icache2core_data_valid,
  output logic         icache2mem_req,
  output logic [31:0]  icache2mem_addr,
  input  logic         mem2icache_ready,
  input  logic [127:0] mem2icache_data,
  input  logic         mem2icache_data_valid,
  output logic [1:0]   icache_state
`ifdef ICACHE_STATS_EN
  , output logic [31:0] icache_hit_count
  , output logic [31:0] icache_miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ICACHE_LADDR_W - IDX_W;

  icache_line_t       data_arr [LINES];
  logic [TAG_W-1:0]   tag_arr  [LINES];
  logic [LINES-1:0]   valid_r;

  logic [ICACHE_LADDR_W-1:0] line_a, line_b, miss_line;
  logic [IDX_W-1:0]          idx_a, idx_b, wr_idx;
  logic [TAG_W-1:0]          tag_a, tag_b, wr_tag;
  logic                      hit_a, hit_b, need_b, hit;
  logic                      wr_en, miss_start;
  icache_line_t              wr_data, window;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^core2icache_addr[1:0];

  assign line_a = core2icache_addr[31:ICACHE_OFF_W];
  assign line_b = line_a + ICACHE_LADDR_W'(1);  // wraps modulo 2^32 bytes
  assign idx_a  = line_a[IDX_W-1:0];
  assign idx_b  = line_b[IDX_W-1:0];
  assign tag_a  = line_a[ICACHE_LADDR_W-1 -: TAG_W];
  assign tag_b  = line_b[ICACHE_LADDR_W-1 -: TAG_W];

  assign need_b = (core2icache_addr[3:2] != 2'd0);
  assign hit_a  = valid_r[idx_a] && (tag_arr[idx_a] == tag_a);
  assign hit_b  = valid_r[idx_b] && (tag_arr[idx_b] == tag_b);
  assign hit    = hit_a && (!need_b || hit_b);

  // Missing line to fetch first: A if absent, otherwise B.
  assign miss_line = hit_a ? line_b : line_a;

  // Window = ({B, A} >> 32*addr[3:2])[127:0], forced to zero on a miss.
  always_comb begin
    window = '0;
    if (hit) begin
      case (core2icache_addr[3:2])
        2'd0: window = data_arr[idx_a];
        2'd1: window = {data_arr[idx_b][31:0], data_arr[idx_a][127:32]};
        2'd2: window = {data_arr[idx_b][63:0], data_arr[idx_a][127:64]};
        default: window = {data_arr[idx_b][95:0], data_arr[idx_a][127:96]};
      endcase
    end
  end

  assign icache2core_data       = window;
  assign icache2core_data_valid = hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
    end else if (icache_flush) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Contents are only meaningful where valid_r is set, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_arr[wr_idx] <= wr_data;
      tag_arr[wr_idx]  <= wr_tag;
    end
  end

  icache_refill #(
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_refill (
    .clock      (clock),
    .reset      (reset),
    .miss       (!hit),
    .miss_line  (miss_line),
    .flush      (icache_flush),
    .mem_req    (icache2mem_req),
    .mem_addr   (icache2mem_addr),
    .mem_ready  (mem2icache_ready),
    .mem_data   (mem2icache_data),
    .mem_valid  (mem2icache_data_valid),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_tag     (wr_tag),
    .wr_data    (wr_data),
    .miss_start (miss_start),
    .state      (icache_state)
  );

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_r, miss_cnt_r;

  // Cleared by reset only; a flush leaves the statistics alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else begin
      if (hit)        hit_cnt_r  <= hit_cnt_r + 32'd1;
      if (miss_start) miss_cnt_r <= miss_cnt_r + 32'd1;
    end
  end

  assign icache_hit_count  = hit_cnt_r;
  assign icache_miss_count = miss_cnt_r;
`else
  logic unused_miss_start;
  assign unused_miss_start = miss_start;
`endif

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache
// Directed timing scenarios followed by randomized fetches for icache.
// Memory word at byte address a is (a << 5) + 0x13, so line 0 holds
// {0x13, 0x93, 0x113, 0x193}. The reference model tracks which line
// addresses are resident and derives windows straight from that rule.
// -----------------------------------------------------------------------------
module tb_icache;
  import icache_pkg::*;

  localparam int LINES = 64;

  logic         clock;
  logic         reset;
  logic [31:0]  core2icache_addr;
  logic         icache_flush;
  logic [127:0] icache2core_data;
  logic         icache2core_data_valid;
  logic         icache2mem_req;
  logic [31:0]  icache2mem_addr;
  logic         mem2icache_ready;
  logic [127:0] mem2icache_data;
  logic         mem2icache_data_valid;
  logic [1:0]   icache_state;
`ifdef ICACHE_STATS_EN
  logic [31:0]  icache_hit_count;
  logic [31:0]  icache_miss_count;
`endif

  icache #(.LINES(LINES)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .core2icache_addr       (core2icache_addr),
    .icache_flush           (icache_flush),
    .icache2core_data       (icache2core_data),
    .icache2core_data_valid (icache2core_data_valid),
    .icache2mem_req         (icache2mem_req),
    .icache2mem_addr        (icache2mem_addr),
    .mem2icache_ready       (mem2icache_ready),
    .mem2icache_data        (mem2icache_data),
    .mem2icache_data_valid  (mem2icache_data_valid),
    .icache_state           (icache_state)
`ifdef ICACHE_STATS_EN
    , .icache_hit_count     (icache_hit_count)
    , .icache_miss_count    (icache_miss_count)
`endif
  );

  // ---------------- clock / watchdog ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          ready_mode = 1;   // 0: never ready, 1: always ready, 2: random
  int          dly_max = 0;      // extra cycles before the fill returns
  logic [31:0] req_log[$];       // accepted fill addresses
  bit          m_valid[LINES];
  logic [27:0] m_line[LINES];
  bit          outstanding, drop, req_prev;
  logic [27:0] pend_line;
  int          dly, m_idx;
  int unsigned exp_hits, exp_misses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 5) + 32'h13;
  endfunction

  function automatic logic [127:0] exp_win(input logic [31:0] a);
    logic [31:0] a0;
    a0 = {a[31:2], 2'b00};
    return {mem_word(a0 + 32'd12), mem_word(a0 + 32'd8),
            mem_word(a0 + 32'd4), mem_word(a0)};
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    logic [27:0] la, lb;
    int ia, ib;
    la = a[31:4];
    lb = la + 28'd1;
    ia = int'(la % LINES);
    ib = int'(lb % LINES);
    return m_valid[ia] && (m_line[ia] == la) &&
           ((a[3:2] == 2'd0) || (m_valid[ib] && (m_line[ib] == lb)));
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    bit h;
    h = m_hit(core2icache_addr);
    chk({tag, "_valid"}, 128'(icache2core_data_valid), 128'(h));
    chk({tag, "_data"}, icache2core_data, h ? exp_win(core2icache_addr) : 128'd0);
  endtask

  task automatic wait_hit(input string tag);
    int k;
    k = 0;
    #1;
    while (!icache2core_data_valid && k < 64) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk({tag, "_hit_in_time"}, 128'(icache2core_data_valid), 128'd1);
  endtask

  // ---------------- memory responder + reference model ----------------
  always begin
    @(posedge clock);
    if (!reset) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      outstanding = 1'b0;
      drop        = 1'b0;
      req_prev    = 1'b0;
      exp_hits    = 0;
      exp_misses  = 0;
    end else begin
      if (icache2core_data_valid) exp_hits++;
      if (icache2mem_req && !req_prev) exp_misses++;
      req_prev = icache2mem_req;
      if (icache_flush) begin
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        if (outstanding) drop = 1'b1;
      end
      if (mem2icache_data_valid) begin
        if (!icache_flush && !drop) begin
          m_idx = int'(pend_line % LINES);
          m_valid[m_idx] = 1'b1;
          m_line[m_idx]  = pend_line;
        end
        drop        = 1'b0;
        outstanding = 1'b0;
      end
      if (icache2mem_req && mem2icache_ready) begin
        outstanding = 1'b1;
        pend_line   = icache2mem_addr[31:4];
        req_log.push_back(icache2mem_addr);
        dly = $urandom_range(0, dly_max);
      end
    end
    @(negedge clock);
    mem2icache_data_valid = 1'b0;
    if (reset && outstanding) begin
      if (dly == 0) begin
        mem2icache_data_valid = 1'b1;
        mem2icache_data = exp_win({pend_line, 4'h0});
      end else begin
        dly--;
      end
    end
    case (ready_mode)
      0:       mem2icache_ready = 1'b0;
      1:       mem2icache_ready = 1'b1;
      default: mem2icache_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int          hold;
    int          r;
    logic [27:0] ln;

    reset = 1'b0;
    core2icache_addr = 32'h0;
    icache_flush = 1'b0;
    mem2icache_ready = 1'b1;
    mem2icache_data = '0;
    mem2icache_data_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    #1;
    chk("rst_valid", 128'(icache2core_data_valid), 128'd0);
    chk("rst_data", icache2core_data, 128'd0);
    chk("rst_req", 128'(icache2mem_req), 128'd0);
    chk("rst_mem_addr", 128'(icache2mem_addr), 128'd0);
    chk("rst_state", 128'(icache_state), 128'(IDLE));

    // Cold fetch at 0x0: miss-to-hit in 3 cycles, one request
    @(negedge clock);
    reset = 1'b1;
    req_log.delete();
    #1 chk("cold_c0_valid", 128'(icache2core_data_valid), 128'd0);
    @(negedge clock);
    #1 chk("cold_c1_valid", 128'(icache2core_data_valid), 128'd0);
    chk("cold_c1_req", 128'(icache2mem_req), 128'd1);
    chk("cold_c1_addr", 128'(icache2mem_addr), 128'd0);
    @(negedge clock);
    #1 chk("cold_c2_valid", 128'(icache2core_data_valid), 128'd0);
    chk("cold_c2_req", 128'(icache2mem_req), 128'd0);
    @(negedge clock);
    #1 chk("cold_c3_valid", 128'(icache2core_data_valid), 128'd1);
    chk("cold_c3_word0", 128'(icache2core_data[31:0]), 128'h13);
    chk("cold_c3_window", icache2core_data, exp_win(32'h0));
    chk("cold_nreq", 128'(req_log.size()), 128'd1);
    chk("cold_req0", 128'(req_log[0]), 128'd0);

    // Unaligned 0x18, both lines cold: fills 0x10 then 0x20, hit in cycle 6
    @(negedge clock);
    icache_flush = 1'b1;
    core2icache_addr = 32'h18;
    req_log.delete();
    @(negedge clock);
    icache_flush = 1'b0;
    #1 chk("ua_c0_valid", 128'(icache2core_data_valid), 128'd0);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clock);
      #1;
      if (cyc == 1) chk("ua_c1_addr", 128'(icache2mem_addr), 128'h10);
      if (cyc == 4) chk("ua_c4_addr", 128'(icache2mem_addr), 128'h20);
      if (cyc == 5) chk("ua_c5_valid", 128'(icache2core_data_valid), 128'd0);
      if (cyc == 6) chk("ua_c6_valid", 128'(icache2core_data_valid), 128'd1);
    end
    chk("ua_window", icache2core_data, exp_win(32'h18));
    chk("ua_nreq", 128'(req_log.size()), 128'd2);

    // Conflict: 0x0 and 0x400 share an index
    @(negedge clock);
    icache_flush = 1'b1;
    core2icache_addr = 32'h0;
    @(negedge clock);
    icache_flush = 1'b0;
    wait_hit("cf_a");
    @(negedge clock);
    core2icache_addr = 32'h400;
    #1 chk("cf_b_miss", 128'(icache2core_data_valid), 128'd1 - 128'd1);
    wait_hit("cf_b");
    chk("cf_b_req", 128'(req_log[$]), 128'h400);
    chk_model("cf_b");
    @(negedge clock);
    core2icache_addr = 32'h0;
    #1 chk("cf_a2_miss", 128'(icache2core_data_valid), 128'd0);
    wait_hit("cf_a2");
    chk("cf_a2_req", 128'(req_log[$]), 128'h0);

    // Flush in WAIT with the fill on the same edge: fill discarded
    @(negedge clock);
    icache_flush = 1'b1;
    core2icache_addr = 32'h40;
    @(negedge clock);
    icache_flush = 1'b0;
    req_log.delete();
    @(negedge clock);
    #1 chk("fw_c1_req", 128'(icache2mem_req), 128'd1);
    @(negedge clock);
    icache_flush = 1'b1;
    @(negedge clock);
    icache_flush = 1'b0;
    #1 chk("fw_c3_state", 128'(icache_state), 128'(IDLE));
    chk("fw_c3_valid", 128'(icache2core_data_valid), 128'd0);
    chk("fw_c3_req", 128'(icache2mem_req), 128'd0);
    @(negedge clock);
    #1 chk("fw_c4_req", 128'(icache2mem_req), 128'd1);
    chk("fw_c4_addr", 128'(icache2mem_addr), 128'h40);
    wait_hit("fw");
    chk("fw_nreq", 128'(req_log.size()), 128'd2);

    // Reset while REQ waits on ready: req drops at once, no stale fill
    @(negedge clock);
    icache_flush = 1'b1;
    core2icache_addr = 32'h80;
    ready_mode = 0;
    @(negedge clock);
    icache_flush = 1'b0;
    req_log.delete();
    @(negedge clock);
    #1 chk("rr_c1_req", 128'(icache2mem_req), 128'd1);
    @(negedge clock);
    #1 chk("rr_c2_req", 128'(icache2mem_req), 128'd1);
    chk("rr_c2_addr", 128'(icache2mem_addr), 128'h80);
    #1 reset = 1'b0;
    #1 chk("rr_async_req", 128'(icache2mem_req), 128'd0);
    chk("rr_async_state", 128'(icache_state), 128'(IDLE));
    @(negedge clock);
    reset = 1'b1;
    core2icache_addr = 32'h200;
    #1 chk("rr_post_valid", 128'(icache2core_data_valid), 128'd0);
    @(negedge clock);
    #1 chk("rr_post_req", 128'(icache2mem_req), 128'd1);
    chk("rr_post_addr", 128'(icache2mem_addr), 128'h200);
    repeat (2) begin
      @(negedge clock);
      #1 chk("rr_hold_valid", 128'(icache2core_data_valid), 128'd0);
    end
    ready_mode = 1;
    wait_hit("rr");
    chk("rr_nreq", 128'(req_log.size()), 128'd1);
    chk("rr_req0", 128'(req_log[0]), 128'h200);

`ifdef ICACHE_STATS_EN
    @(negedge clock);
    #1 chk("st_hits", 128'(icache_hit_count), 128'(exp_hits));
    chk("st_misses", 128'(icache_miss_count), 128'(exp_misses));
    @(negedge clock);
    icache_flush = 1'b1;
    @(negedge clock);
    icache_flush = 1'b0;
    #1 chk("st_flush_hits", 128'(icache_hit_count), 128'(exp_hits));
    chk("st_flush_misses", 128'(icache_miss_count), 128'(exp_misses));
`endif

    // Random fetches against the reference model, random ready/latency/flush
    ready_mode = 2;
    dly_max = 2;
    for (int it = 0; it < 250; it++) begin
      hold = $urandom_range(1, 6);
      r = $urandom_range(0, 9);
      if (r == 0)      ln = 28'hFFF_FFFF;
      else if (r < 4)  ln = 28'($urandom_range(0, 5) + 64);
      else             ln = 28'($urandom_range(0, 5));
      for (int c = 0; c < hold; c++) begin
        @(negedge clock);
        if (c == 0) core2icache_addr = {ln, 4'($urandom_range(0, 15))};
        icache_flush = ($urandom_range(0, 29) == 0);
        #1 chk_model("rnd");
      end
    end
    @(negedge clock);
    icache_flush = 1'b0;

`ifdef ICACHE_STATS_EN
    repeat (12) @(negedge clock);
    #1 chk("st_end_hits", 128'(icache_hit_count), 128'(exp_hits));
    chk("st_end_misses", 128'(icache_miss_count), 128'(exp_misses));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
